// File: rtl/seg_scan_capture.sv
// Recovers the two-digit BCD value from a multiplexed 7-segment bus; publishes after STABLE_SCANS identical frames.
// Latency: units sample at com change + SETTLE, num_out 2 cycles later; no backpressure (pure monitor).
module seg_scan_capture #(
  parameter int unsigned SETTLE       = 4,
  parameter int unsigned STABLE_SCANS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] com_in,
  input  logic [6:0] light_in,
  output logic [7:0] num_out,
  output logic       num_valid,
  output logic       num_update,
  output logic       seg_err
);

  localparam logic [7:0] SETTLE_LD  = 8'(SETTLE);
  localparam logic [3:0] STABLE_MAX = 4'(STABLE_SCANS);

  typedef enum logic [0:0] {S_IDLE, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic [1:0]  com_prev_q, com_prev_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        tgt_tens_q, tgt_tens_d;
  logic [3:0]  tens_q, tens_d;
  logic        tens_flag_q, tens_flag_d;
  logic [7:0]  cand_q, cand_d;
  logic [3:0]  stable_q, stable_d;
  logic        frame_done_q, frame_done_d;
  logic [7:0]  num_out_q, num_out_d;
  logic        num_valid_q, num_valid_d;
  logic        num_update_q, num_update_d;
  logic        seg_err_q, seg_err_d;

  logic        expire;
  logic [4:0]  dec;
  logic [7:0]  frame;

  // Returns {legal, digit}.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1111110: r = {1'b1, 4'd0};
      7'b0110000: r = {1'b1, 4'd1};
      7'b1101101: r = {1'b1, 4'd2};
      7'b1111001: r = {1'b1, 4'd3};
      7'b0110011: r = {1'b1, 4'd4};
      7'b1011011: r = {1'b1, 4'd5};
      7'b1011111: r = {1'b1, 4'd6};
      7'b1110000: r = {1'b1, 4'd7};
      7'b1111111: r = {1'b1, 4'd8};
      7'b1111011: r = {1'b1, 4'd9};
      default:    r = 5'd0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    com_prev_d   = com_in;
    cnt_d        = cnt_q;
    tgt_tens_d   = tgt_tens_q;
    tens_d       = tens_q;
    tens_flag_d  = tens_flag_q;
    cand_d       = cand_q;
    stable_d     = stable_q;
    frame_done_d = 1'b0;
    num_out_d    = num_out_q;
    num_valid_d  = num_valid_q;
    num_update_d = 1'b0;
    seg_err_d    = 1'b0;
    dec          = seg_decode(light_in);
    frame        = {tens_q, dec[3:0]};
    expire       = (state_q == S_WAIT) && (cnt_q == 8'd1);

    if (state_q == S_WAIT) begin
      cnt_d = cnt_q - 8'd1;
    end

    // Sample stage: the expiring digit is taken before any same-cycle com change re-arms.
    if (expire) begin
      state_d = S_IDLE;
      if (!dec[4]) begin
        seg_err_d   = 1'b1;
        tens_flag_d = 1'b0;
        stable_d    = 4'd0;
      end else if (tgt_tens_q) begin
        tens_d      = dec[3:0];
        tens_flag_d = 1'b1;
      end else if (tens_flag_q) begin
        tens_flag_d  = 1'b0;
        frame_done_d = 1'b1;
        if ((frame == cand_q) && (stable_q != 4'd0)) begin
          if (stable_q < STABLE_MAX) begin
            stable_d = stable_q + 4'd1;
          end
        end else begin
          cand_d   = frame;
          stable_d = 4'd1;
        end
      end
    end

    if (com_in != com_prev_q) begin
      if ((com_in == 2'b10) || (com_in == 2'b01)) begin
        state_d    = S_WAIT;
        cnt_d      = SETTLE_LD;
        tgt_tens_d = (com_in == 2'b10);
      end else begin
        state_d = S_IDLE;
      end
    end

    // Publish stage: only a just-completed frame can move num_out.
    if (frame_done_q && (stable_q == STABLE_MAX)) begin
      num_out_d    = cand_q;
      num_valid_d  = 1'b1;
      num_update_d = !num_valid_q || (cand_q != num_out_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      com_prev_q   <= 2'b00;
      cnt_q        <= 8'd0;
      tgt_tens_q   <= 1'b0;
      tens_q       <= 4'd0;
      tens_flag_q  <= 1'b0;
      cand_q       <= 8'h00;
      stable_q     <= 4'd0;
      frame_done_q <= 1'b0;
      num_out_q    <= 8'h00;
      num_valid_q  <= 1'b0;
      num_update_q <= 1'b0;
      seg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      com_prev_q   <= com_prev_d;
      cnt_q        <= cnt_d;
      tgt_tens_q   <= tgt_tens_d;
      tens_q       <= tens_d;
      tens_flag_q  <= tens_flag_d;
      cand_q       <= cand_d;
      stable_q     <= stable_d;
      frame_done_q <= frame_done_d;
      num_out_q    <= num_out_d;
      num_valid_q  <= num_valid_d;
      num_update_q <= num_update_d;
      seg_err_q    <= seg_err_d;
    end
  end

  assign num_out    = num_out_q;
  assign num_valid  = num_valid_q;
  assign num_update = num_update_q;
  assign seg_err    = seg_err_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Scoreboard bench for seg_scan_capture: a reference model queues each expected publish,
// and a negedge monitor pops one entry per num_update pulse.
module tb_seg_scan_capture;

  localparam int STABLE = 2;
  localparam int DWELL  = 51;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] com_in;
  logic [6:0] light_in;
  logic [7:0] num_out;
  logic       num_valid;
  logic       num_update;
  logic       seg_err;

  int total = 0;
  int bad   = 0;
  int upd_cnt = 0;
  int err_cnt = 0;
  int exp_err = 0;

  logic [7:0] exp_q[$];
  logic [6:0] segtab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                              7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  // Reference model state
  logic [3:0] m_tens;
  logic       m_tflag;
  logic [7:0] m_cand;
  int         m_stable;
  logic [7:0] m_pub;
  logic       m_valid;

  seg_scan_capture #(.SETTLE(4), .STABLE_SCANS(STABLE)) dut (
    .clk(clk), .rst(rst), .com_in(com_in), .light_in(light_in),
    .num_out(num_out), .num_valid(num_valid), .num_update(num_update), .seg_err(seg_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [7:0] e;
    if (seg_err) err_cnt++;
    if (num_update) begin
      upd_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL upd_unexpected: num_out=%h, required no update pulse", num_out);
      end else begin
        e = exp_q.pop_front();
        if (num_out !== e) begin
          bad++;
          $display("FAIL upd_value: num_out=%h, required %h", num_out, e);
        end
      end
    end
  end

  task automatic model_reset();
    m_tens = 0; m_tflag = 0; m_cand = 0; m_stable = 0; m_pub = 0; m_valid = 0;
  endtask

  task automatic model_sample(input bit is_tens, input logic [6:0] seg);
    int d;
    logic [7:0] fr;
    d = -1;
    for (int i = 0; i < 10; i++) if (segtab[i] == seg) d = i;
    if (d < 0) begin
      exp_err++;
      m_tflag = 0;
      m_stable = 0;
    end else if (is_tens) begin
      m_tens = 4'(d);
      m_tflag = 1;
    end else if (m_tflag) begin
      m_tflag = 0;
      fr = {m_tens, 4'(d)};
      if (fr == m_cand && m_stable > 0) begin
        if (m_stable < STABLE) m_stable++;
      end else begin
        m_cand = fr;
        m_stable = 1;
      end
      if (m_stable == STABLE) begin
        if (!m_valid || m_cand != m_pub) exp_q.push_back(m_cand);
        m_pub = m_cand;
        m_valid = 1;
      end
    end
  endtask

  // Entered and left at posedge+1.
  task automatic drive(input logic [1:0] c, input logic [6:0] s, input int cycles);
    com_in = c;
    light_in = s;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic scan_frame(input logic [6:0] ts, input logic [6:0] us);
    model_sample(1'b1, ts);
    drive(2'b10, ts, DWELL);
    model_sample(1'b0, us);
    drive(2'b01, us, DWELL);
  endtask

  task automatic test_reset();
    rst = 1'b0; com_in = 2'b00; light_in = 7'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total += 4;
    if (num_out !== 8'h00)  begin bad++; $display("FAIL rst_num_out: got %h, required 00", num_out); end
    if (num_valid !== 1'b0) begin bad++; $display("FAIL rst_num_valid: got %b, required 0", num_valid); end
    if (num_update !== 1'b0) begin bad++; $display("FAIL rst_num_update: got %b, required 0", num_update); end
    if (seg_err !== 1'b0)   begin bad++; $display("FAIL rst_seg_err: got %b, required 0", seg_err); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_first_value();
    int u0;
    u0 = upd_cnt;
    scan_frame(segtab[2], segtab[5]);
    total++;
    if (num_valid !== 1'b0) begin bad++; $display("FAIL first_valid_early: got %b, required 0", num_valid); end
    scan_frame(segtab[2], segtab[5]);
    total += 3;
    if (num_out !== 8'h25)  begin bad++; $display("FAIL first_num_out: got %h, required 25", num_out); end
    if (num_valid !== 1'b1) begin bad++; $display("FAIL first_valid: got %b, required 1", num_valid); end
    if (upd_cnt - u0 !== 1) begin bad++; $display("FAIL first_upd_count: got %0d, required 1", upd_cnt - u0); end
  endtask

  task automatic test_change();
    int u0;
    scan_frame(segtab[2], segtab[5]);
    u0 = upd_cnt;
    scan_frame(segtab[2], segtab[9]);
    total++;
    if (num_out !== 8'h25) begin bad++; $display("FAIL change_hold: got %h, required 25", num_out); end
    scan_frame(segtab[2], segtab[9]);
    total += 2;
    if (num_out !== 8'h29)  begin bad++; $display("FAIL change_num_out: got %h, required 29", num_out); end
    if (upd_cnt - u0 !== 1) begin bad++; $display("FAIL change_upd_count: got %0d, required 1", upd_cnt - u0); end
  endtask

  task automatic test_illegal();
    int e0, u0;
    e0 = err_cnt;
    u0 = upd_cnt;
    scan_frame(segtab[3], segtab[1]);
    scan_frame(7'b0000001, segtab[9]);
    total += 2;
    if (err_cnt - e0 !== 1)  begin bad++; $display("FAIL illegal_err_count: got %0d, required 1", err_cnt - e0); end
    if (num_out !== 8'h29)   begin bad++; $display("FAIL illegal_hold: got %h, required 29", num_out); end
    scan_frame(segtab[3], segtab[1]);
    total += 2;
    if (num_out !== 8'h29)   begin bad++; $display("FAIL illegal_restart: got %h, required 29", num_out); end
    if (err_cnt - e0 !== exp_err - e0) begin bad++; $display("FAIL illegal_err_model: got %0d, required %0d", err_cnt, exp_err); end
    scan_frame(segtab[3], segtab[1]);
    total += 2;
    if (num_out !== 8'h31)  begin bad++; $display("FAIL illegal_recover: got %h, required 31", num_out); end
    if (upd_cnt - u0 !== 1) begin bad++; $display("FAIL illegal_upd_count: got %0d, required 1", upd_cnt - u0); end
  endtask

  task automatic test_abort();
    int u0;
    u0 = upd_cnt;
    model_sample(1'b1, segtab[4]);
    drive(2'b10, segtab[4], DWELL);
    drive(2'b01, segtab[6], 2);
    model_sample(1'b1, segtab[4]);
    drive(2'b10, segtab[4], DWELL);
    total += 2;
    if (num_out !== 8'h31)  begin bad++; $display("FAIL abort_hold: got %h, required 31", num_out); end
    if (upd_cnt - u0 !== 0) begin bad++; $display("FAIL abort_upd_count: got %0d, required 0", upd_cnt - u0); end
  endtask

  task automatic test_idle();
    int u0, e0;
    u0 = upd_cnt;
    e0 = err_cnt;
    drive(2'b00, 7'b0000001, 200);
    total += 3;
    if (num_out !== 8'h31)  begin bad++; $display("FAIL idle_hold: got %h, required 31", num_out); end
    if (err_cnt - e0 !== 0) begin bad++; $display("FAIL idle_err: got %0d, required 0", err_cnt - e0); end
    if (upd_cnt - u0 !== 0) begin bad++; $display("FAIL idle_upd: got %0d, required 0", upd_cnt - u0); end
    scan_frame(segtab[0], segtab[7]);
    total++;
    if (num_out !== 8'h31) begin bad++; $display("FAIL resume_hold: got %h, required 31", num_out); end
    scan_frame(segtab[0], segtab[7]);
    total++;
    if (num_out !== 8'h07) begin bad++; $display("FAIL resume_num_out: got %h, required 07", num_out); end
  endtask

  task automatic test_reset_mid();
    int u0;
    drive(2'b10, segtab[2], 20);
    rst = 1'b0;
    #1;
    total += 3;
    if (num_out !== 8'h00)  begin bad++; $display("FAIL midrst_num_out: got %h, required 00", num_out); end
    if (num_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b, required 0", num_valid); end
    if (seg_err !== 1'b0)   begin bad++; $display("FAIL midrst_seg_err: got %b, required 0", seg_err); end
    model_reset();
    com_in = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    u0 = upd_cnt;
    scan_frame(segtab[2], segtab[5]);
    total++;
    if (num_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid_early: got %b, required 0", num_valid); end
    scan_frame(segtab[2], segtab[5]);
    total += 3;
    if (num_out !== 8'h25)  begin bad++; $display("FAIL midrst_num_out2: got %h, required 25", num_out); end
    if (num_valid !== 1'b1) begin bad++; $display("FAIL midrst_valid2: got %b, required 1", num_valid); end
    if (upd_cnt - u0 !== 1) begin bad++; $display("FAIL midrst_upd_count: got %0d, required 1", upd_cnt - u0); end
  endtask

  initial begin
    test_reset();
    test_first_value();
    test_change();
    test_illegal();
    test_abort();
    test_idle();
    test_reset_mid();
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive side of the two-digit multiplexed 7-segment bus: monitors `com`/`light` as driven onto the display and reconstructs the displayed two-digit BCD value.
- Used for loopback self-check of the display path and as a bench/board monitor.
- Samples each digit after a settle delay, decodes segments back to BCD, and publishes a value only after it is stable for several complete scans.

Parameters:
- SETTLE, 4: clk cycles after a `com_in` change before `light_in` is sampled (range 1..255).
- STABLE_SCANS, 2: consecutive identical complete frames needed before `num_out` updates (range 1..15).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- com_in  input  2  digit select from display bus; 2'b10 = tens active, 2'b01 = units active, 00/11 = idle
- light_in  input  7  segment lines {a,b,c,d,e,f,g}, active-high
- num_out  output  8  captured value, [7:4] tens BCD, [3:0] units BCD
- num_valid  output  1  high once at least one value has been published; stays high until reset
- num_update  output  1  one-cycle pulse when `num_out` changes value
- seg_err  output  1  one-cycle pulse when a sampled pattern is not a legal digit

Behaviour:
- Reset (`rst` low, async): `num_out`=8'h00, `num_valid`=0, `num_update`=0, `seg_err`=0. Also clears:
  - `com_prev`=2'b00, settle counter=0, sampling idle;
  - tens/units capture registers and their flags;
  - candidate=8'h00, stable count=0.
- Change detect: `com_prev` is registered every cycle; a change is `com_in` != `com_prev`.
- On a change to 2'b10 or 2'b01: load settle counter with SETTLE and arm a sample for that digit.
- On a change to 00/11: disarm; no sample is taken.
- Each cycle while armed: counter decrements. When it reaches 0, sample `light_in` in that cycle and disarm.
- A `com_in` change before the counter expires aborts the pending sample; the new value re-arms if it is a valid select.
- Decode table (`light_in` -> digit):
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4;
  - 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9.
  - Any other pattern is illegal.
- Legal sample: store the digit in the tens or units capture register and set that digit's flag.
- Illegal sample:
  - `seg_err` pulses for 1 cycle after the sample cycle;
  - both capture flags clear and stable count resets to 0;
  - `num_out` is unchanged.
- Frame definition: a tens capture followed by a units capture.
  - A units capture without the tens flag set is discarded.
  - A second tens capture before units overwrites the tens register.
- Frame completion (units captured with tens flag set): frame = {tens, units}; both flags clear.
  - If frame == candidate and stable count > 0: stable count += 1, saturating at STABLE_SCANS.
  - Otherwise: candidate = frame, stable count = 1.
- Publish: in the cycle after stable count reaches STABLE_SCANS (including STABLE_SCANS=1), `num_out` <= candidate and `num_valid` <= 1.
  - `num_update` pulses only if the candidate differs from the old `num_out`, or on the first publish after reset.
  - Further identical frames cause no pulses.
- Latency: units sample at change+SETTLE cycles; `num_out` updates 2 cycles after that sample (frame/compare stage, then publish stage).
- Simultaneous events: a `com_in` change in the same cycle the counter expires still samples first (the sample belongs to the old digit); the change arms the new one.
- A frame differing from the published value never partially updates `num_out`; the old value holds until the new frame is stable.
- Reset mid-operation: all state clears immediately; the first publish after reset needs STABLE_SCANS fresh frames.

Test Plan:
- Drive 10/01 alternation at 51-cycle dwell, pattern 1101101 on tens and 1011011 on units, STABLE_SCANS=2 -> `num_out`=8'h25, `num_valid`=1 after the second frame, exactly one `num_update` pulse.
- Hold 8'h25 steady, then switch units to 1111011 -> first 8'h29 frame leaves `num_out`=8'h25; after the second 8'h29 frame, `num_out`=8'h29 with one `num_update`.
- Inject illegal tens pattern 0000001 for one scan -> one `seg_err` pulse, `num_out` held at 8'h29, and stable count restarts (two good frames needed).
- Toggle `com_in` back to 10 within 2 cycles of switching to 01 (SETTLE=4) -> units sample aborted, no frame completes, no `num_update`.
- Set `com_in`=00 for 200 cycles -> no sampling, outputs unchanged; resuming 10/01 with 8'h07 patterns -> `num_out`=8'h07 after 2 frames.
- Assert `rst` low mid-scan -> all outputs 0 immediately; after release, 2 good frames of 8'h25 -> `num_valid`=1 and `num_update` pulses.
